// File: rtl/psum_accum.sv
// psum_accum: output-side accumulator behind the PE array.
// Captures per-column partial sums, accumulates them over G_NUM_PASSES
// input-channel passes with signed saturation, then drains the finished
// ofmap tile column-major on a registered valid/ready stream.
// Optional feature macro: PSUM_ACCUM_RELU_EN (ReLU applied at drain only).
module psum_accum #(
   parameter int G_ARRAY_WIDTH = 4,
   parameter int G_TOP_BITS    = 2,
   parameter int G_BOT_BITS    = 14,
   parameter int G_OFMAP_WIDTH = 24,
   parameter int G_NUM_PASSES  = 3
) (
   input  logic                                                 clk_i,
   input  logic                                                 rst_i,
   input  logic                                                 start_i,
   input  logic [0:G_ARRAY_WIDTH-1]                             psum_vld_i,
   input  logic [0:G_ARRAY_WIDTH-1][G_TOP_BITS+G_BOT_BITS-1:0]  psum_i,
   output logic                                                 ofmap_vld_o,
   input  logic                                                 ofmap_rdy_i,
   output logic [G_TOP_BITS+G_BOT_BITS-1:0]                     ofmap_o,
   output logic                                                 ofmap_last_o,
   output logic                                                 busy_o,
   output logic                                                 done_o,
   output logic                                                 overflow_o
);

   localparam int D  = G_TOP_BITS + G_BOT_BITS;
   localparam int XW = $clog2(G_OFMAP_WIDTH + 1);
   localparam int CW = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1;
   localparam int PW = (G_NUM_PASSES > 1) ? $clog2(G_NUM_PASSES) : 1;

   localparam logic [XW-1:0]       X_FULL = XW'(G_OFMAP_WIDTH);
   localparam logic [XW-1:0]       X_LAST = XW'(G_OFMAP_WIDTH - 1);
   localparam logic [CW-1:0]       C_LAST = CW'(G_ARRAY_WIDTH - 1);
   localparam logic [PW-1:0]       P_LAST = PW'(G_NUM_PASSES - 1);
   localparam logic signed [D-1:0] S_MAX  = {1'b0, {(D-1){1'b1}}};
   localparam logic signed [D-1:0] S_MIN  = {1'b1, {(D-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t state;
   state_t state_nxt;

   logic signed [D-1:0] buf_mem [G_ARRAY_WIDTH][G_OFMAP_WIDTH];
   logic [XW-1:0]       wr_idx  [G_ARRAY_WIDTH];
   logic [PW-1:0]       pass_cnt;
   logic [CW-1:0]       rd_c;
   logic [XW-1:0]       rd_x;
   logic                rd_end;

   logic [0:G_ARRAY_WIDTH-1] wr_en;
   logic [0:G_ARRAY_WIDTH-1] col_full;
   logic signed [D:0]        sum_ext [G_ARRAY_WIDTH];
   logic signed [D-1:0]      wr_val  [G_ARRAY_WIDTH];
   logic                     pass_done;
   logic                     tile_done;
   logic                     drop;
   logic                     start_acc;
   logic                     drain_load;
   logic                     drain_hs;
   logic                     last_hs;
   logic signed [D-1:0]      rd_val;
   logic signed [D-1:0]      rd_out;

   // Per-column write enables, saturating sums, drop detection and pass completion
   always_comb begin
      pass_done = (state == ACCUM);
      drop      = (state == DRAIN) && (|psum_vld_i);
      for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
         wr_en[c]    = (state == ACCUM) && psum_vld_i[c] && (wr_idx[c] != X_FULL);
         col_full[c] = (wr_idx[c] == X_FULL) || (wr_en[c] && (wr_idx[c] == X_LAST));
         sum_ext[c]  = {buf_mem[c][wr_idx[c]][D-1], buf_mem[c][wr_idx[c]]}
                     + {psum_i[c][D-1], psum_i[c]};
         if (pass_cnt == '0) begin
            wr_val[c] = psum_i[c];
         end else if (sum_ext[c][D] != sum_ext[c][D-1]) begin
            wr_val[c] = sum_ext[c][D] ? S_MIN : S_MAX;
         end else begin
            wr_val[c] = sum_ext[c][D-1:0];
         end
         if ((state == ACCUM) && psum_vld_i[c] && !wr_en[c]) begin
            drop = 1'b1;
         end
         pass_done = pass_done && col_full[c];
      end
      tile_done = pass_done && (pass_cnt == P_LAST);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode: start opens a tile, last pass ends accumulation, last handshake ends drain
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i)   state_nxt = ACCUM;
         ACCUM:   if (tile_done) state_nxt = DRAIN;
         DRAIN:   if (last_hs)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output and control decode from the current state
   always_comb begin
      busy_o     = (state != IDLE);
      start_acc  = (state == IDLE) && start_i;
      drain_hs   = ofmap_vld_o && ofmap_rdy_i;
      last_hs    = drain_hs && ofmap_last_o;
      drain_load = (state == DRAIN) && !rd_end && (!ofmap_vld_o || ofmap_rdy_i);
      rd_val     = buf_mem[rd_c][rd_x];
   end

`ifdef PSUM_ACCUM_RELU_EN
   // Drained values with the sign bit set are forced to zero
   always_comb begin
      rd_out = rd_val[D-1] ? '0 : rd_val;
   end
`else
   // Drained values leave exactly as accumulated
   always_comb begin
      rd_out = rd_val;
   end
`endif

   // Write pointers and pass counter: advance on accepted psums, rewind when a non-final pass completes
   always_ff @(posedge clk_i) begin
      if (rst_i || start_acc) begin
         pass_cnt <= '0;
         for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
            wr_idx[c] <= '0;
         end
      end else if (state == ACCUM) begin
         if (pass_done && (pass_cnt != P_LAST)) begin
            pass_cnt <= pass_cnt + 1'b1;
            for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
               wr_idx[c] <= '0;
            end
         end else begin
            for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
               if (wr_en[c]) begin
                  wr_idx[c] <= wr_idx[c] + 1'b1;
               end
            end
         end
      end
   end

   // Row buffer: first pass overwrites so no clear is needed, later passes store the saturated sum
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
         if (wr_en[c]) begin
            buf_mem[c][wr_idx[c]] <= wr_val[c];
         end
      end
   end

   // Drain output register: load the next element whenever the slot is empty or being consumed
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ofmap_vld_o  <= 1'b0;
         ofmap_last_o <= 1'b0;
         ofmap_o      <= '0;
         rd_c         <= '0;
         rd_x         <= '0;
         rd_end       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         done_o <= last_hs;
         if (start_acc) begin
            rd_c   <= '0;
            rd_x   <= '0;
            rd_end <= 1'b0;
         end
         if (drain_load) begin
            ofmap_o      <= rd_out;
            ofmap_vld_o  <= 1'b1;
            ofmap_last_o <= (rd_c == C_LAST) && (rd_x == X_LAST);
            if (rd_x == X_LAST) begin
               rd_x <= '0;
               if (rd_c == C_LAST) begin
                  rd_c   <= '0;
                  rd_end <= 1'b1;
               end else begin
                  rd_c <= rd_c + 1'b1;
               end
            end else begin
               rd_x <= rd_x + 1'b1;
            end
         end else if (drain_hs) begin
            ofmap_vld_o  <= 1'b0;
            ofmap_last_o <= 1'b0;
         end
      end
   end

   // Sticky overflow: set on any dropped psum, cleared by reset or an accepted start
   always_ff @(posedge clk_i) begin
      if (rst_i || start_acc) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_psum_accum.sv
// Testbench for psum_accum: scoreboard-based checks of accumulation,
// saturation, drain order, backpressure, error flagging and reset abort.
module tb_psum_accum;

   localparam int W = 4;
   localparam int X = 24;
   localparam int P = 3;
   localparam int D = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [0:W-1]       psum_vld;
   logic [0:W-1][D-1:0] psum;
   logic               ofmap_vld;
   logic               ofmap_rdy;
   logic [D-1:0]       ofmap;
   logic               ofmap_last;
   logic               busy;
   logic               done;
   logic               overflow;

   int total = 0;
   int bad   = 0;

   logic signed [D-1:0] stim [P][W][X];
   int                  model [W][X];
   logic [D:0]          exp_q [$];
   logic [D:0]          obs_q [$];
   int                  unstable;
   int                  early_done;
   int                  timed_out;

   psum_accum #(
      .G_ARRAY_WIDTH (W),
      .G_TOP_BITS    (2),
      .G_BOT_BITS    (14),
      .G_OFMAP_WIDTH (X),
      .G_NUM_PASSES  (P)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .psum_vld_i   (psum_vld),
      .psum_i       (psum),
      .ofmap_vld_o  (ofmap_vld),
      .ofmap_rdy_i  (ofmap_rdy),
      .ofmap_o      (ofmap),
      .ofmap_last_o (ofmap_last),
      .busy_o       (busy),
      .done_o       (done),
      .overflow_o   (overflow)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      if (v > (1 << (D-1)) - 1) return (1 << (D-1)) - 1;
      if (v < -(1 << (D-1)))    return -(1 << (D-1));
      return v;
   endfunction

   function automatic logic [D-1:0] out_xform(input int v);
`ifdef PSUM_ACCUM_RELU_EN
      if (v < 0) return '0;
`endif
      return D'(v);
   endfunction

   task automatic start_tile();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives all passes of stim; column c is delayed c*stagger cycles. With
   // extra_col >= 0, pass 0 delays all other columns by 2 and gives extra_col
   // one surplus psum. Expected drain values are pushed to the scoreboard.
   task automatic run_accum(input int stagger, input int extra_col);
      int dly [W];
      int maxdly;
      for (int p = 0; p < P; p++) begin
         maxdly = 0;
         for (int c = 0; c < W; c++) begin
            dly[c] = (extra_col >= 0 && p == 0) ? ((c == extra_col) ? 0 : 2) : c * stagger;
            if (dly[c] > maxdly) maxdly = dly[c];
         end
         for (int t = 0; t < X + maxdly; t++) begin
            for (int c = 0; c < W; c++) begin
               int x;
               x = t - dly[c];
               if (x >= 0 && x < X) begin
                  psum_vld[c] = 1'b1;
                  psum[c]     = stim[p][c][x];
                  model[c][x] = (p == 0) ? int'(stim[p][c][x])
                                         : sat(model[c][x] + int'(stim[p][c][x]));
               end else if (c == extra_col && p == 0 && x == X) begin
                  psum_vld[c] = 1'b1;
                  psum[c]     = 16'h1234;
               end else begin
                  psum_vld[c] = 1'b0;
                  psum[c]     = '0;
               end
            end
            @(negedge clk);
         end
      end
      psum_vld = '0;
      psum     = '0;
      for (int c = 0; c < W; c++) begin
         for (int x = 0; x < X; x++) begin
            exp_q.push_back({(c == W-1 && x == X-1), out_xform(model[c][x])});
         end
      end
   endtask

   // Collects handshaken outputs until the last element or budget expiry
   task automatic drain_collect(input int pct, input int budget);
      logic       prev_stall;
      logic [D:0] prev;
      logic       got_last;
      int         n;
      prev_stall = 1'b0;
      prev       = '0;
      got_last   = 1'b0;
      n          = 0;
      unstable   = 0;
      early_done = 0;
      timed_out  = 0;
      obs_q.delete();
      while (!got_last) begin
         if (n == budget) begin
            timed_out = 1;
            break;
         end
         if (prev_stall && (ofmap_vld !== 1'b1 || {ofmap_last, ofmap} !== prev)) unstable++;
         if (done !== 1'b0) early_done++;
         ofmap_rdy = ($urandom_range(99) < pct);
         if (ofmap_vld && ofmap_rdy) begin
            obs_q.push_back({ofmap_last, ofmap});
            got_last = ofmap_last;
         end
         prev_stall = ofmap_vld && !ofmap_rdy;
         prev       = {ofmap_last, ofmap};
         @(negedge clk);
         n++;
      end
      ofmap_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; psum_vld = '0; psum = '0; ofmap_rdy = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({ofmap_vld, ofmap_last, busy, done, overflow} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got %b want %b", {ofmap_vld, ofmap_last, busy, done, overflow}, 5'b0);
      end
      total++;
      if (ofmap !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL reset_data: got %h want %h", ofmap, 16'h0000);
      end
      rst = 1'b0;
      psum_vld = '1;
      psum = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
      @(negedge clk);
      psum_vld = '0;
      @(negedge clk);
      total++;
      if ({busy, overflow} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL idle_ignores_psum: got %b want %b", {busy, overflow}, 2'b00);
      end
   endtask

   task automatic test_single_pass();
      for (int c = 0; c < W; c++) begin
         for (int x = 0; x < X; x++) begin
            stim[0][c][x] = D'(c * 100 + x);
            stim[1][c][x] = '0;
            stim[2][c][x] = '0;
         end
      end
      start_tile();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL sp_busy_rise: got %b want %b", busy, 1'b1);
      end
      run_accum(0, -1);
      total++;
      if ({ofmap_vld, busy} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL sp_drain_entry: got %b want %b", {ofmap_vld, busy}, 2'b01);
      end
      drain_collect(100, 300);
      total++;
      if (timed_out !== 0 || early_done !== 0) begin
         bad++;
         $display("[TB] FAIL sp_drain: timeout %0d early_done %0d want 0 0", timed_out, early_done);
      end
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++;
         $display("[TB] FAIL sp_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL sp_elem[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
      total++;
      if ({done, ofmap_vld, busy} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL sp_done_pulse: got %b want %b", {done, ofmap_vld, busy}, 3'b100);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL sp_done_width: got %b want %b", done, 1'b0);
      end
   endtask

   task automatic test_staggered();
      for (int p = 0; p < P; p++)
         for (int c = 0; c < W; c++)
            for (int x = 0; x < X; x++)
               stim[p][c][x] = 16'h0400;
      start_tile();
      run_accum(1, -1);
      drain_collect(100, 300);
      total++;
      if (timed_out !== 0 || overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL stag_status: timeout %0d overflow %b want 0 0", timed_out, overflow);
      end
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++;
         $display("[TB] FAIL stag_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL stag_elem[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_saturation();
      for (int c = 0; c < W; c++) begin
         for (int x = 0; x < X; x++) begin
            stim[0][c][x] = (c < 2) ? 16'h7000 : 16'h9000;
            stim[1][c][x] = (c < 2) ? 16'h7000 : 16'h9000;
            stim[2][c][x] = (c == 0) ? 16'hFFFF : (c == 2) ? 16'h0001 : 16'h0000;
         end
      end
      start_tile();
      run_accum(0, -1);
      drain_collect(100, 300);
      total++;
      if (timed_out !== 0) begin
         bad++;
         $display("[TB] FAIL sat_timeout: got %0d want 0", timed_out);
      end
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++;
         $display("[TB] FAIL sat_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL sat_elem[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      for (int p = 0; p < P; p++)
         for (int c = 0; c < W; c++)
            for (int x = 0; x < X; x++)
               stim[p][c][x] = D'($urandom());
      start_tile();
      run_accum(0, -1);
      drain_collect(30, 3000);
      total++;
      if (timed_out !== 0 || unstable !== 0 || early_done !== 0) begin
         bad++;
         $display("[TB] FAIL bp_status: timeout %0d unstable %0d early_done %0d want 0 0 0", timed_out, unstable, early_done);
      end
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++;
         $display("[TB] FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL bp_elem[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_errors();
      for (int p = 0; p < P; p++)
         for (int c = 0; c < W; c++)
            for (int x = 0; x < X; x++)
               stim[p][c][x] = D'($urandom_range(0, 2047));
      start_tile();
      run_accum(0, 1);
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("[TB] FAIL err_25th_flag: got %b want %b", overflow, 1'b1);
      end
      drain_collect(100, 300);
      total++;
      if (obs_q.size() !== exp_q.size() || timed_out !== 0) begin
         bad++;
         $display("[TB] FAIL err_count: got %0d want %0d (timeout %0d)", obs_q.size(), exp_q.size(), timed_out);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL err_elem[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
      start_tile();
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL err_start_clears: got %b want %b", overflow, 1'b0);
      end
      run_accum(0, -1);
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL err_clean_tile: got %b want %b", overflow, 1'b0);
      end
      psum_vld[2] = 1'b1;
      psum[2]     = 16'h0100;
      @(negedge clk);
      psum_vld = '0;
      psum     = '0;
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("[TB] FAIL err_drain_flag: got %b want %b", overflow, 1'b1);
      end
      drain_collect(100, 300);
      total++;
      if (obs_q.size() !== exp_q.size() || timed_out !== 0) begin
         bad++;
         $display("[TB] FAIL err2_count: got %0d want %0d (timeout %0d)", obs_q.size(), exp_q.size(), timed_out);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL err2_elem[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_drain();
      int hs;
      int n;
      for (int p = 0; p < P; p++)
         for (int c = 0; c < W; c++)
            for (int x = 0; x < X; x++)
               stim[p][c][x] = D'($urandom());
      start_tile();
      run_accum(0, -1);
      psum_vld[0] = 1'b1;
      @(negedge clk);
      psum_vld = '0;
      ofmap_rdy = 1'b1;
      hs = 0;
      n  = 0;
      while (hs < 10 && n < 100) begin
         if (ofmap_vld) begin
            total++;
            if ({ofmap_last, ofmap} !== exp_q[hs]) begin
               bad++;
               $display("[TB] FAIL rmd_pre_elem[%0d]: got %h want %h", hs, {ofmap_last, ofmap}, exp_q[hs]);
            end
            hs++;
         end
         @(negedge clk);
         n++;
      end
      total++;
      if (hs !== 10) begin
         bad++;
         $display("[TB] FAIL rmd_handshakes: got %0d want %0d", hs, 10);
      end
      rst       = 1'b1;
      ofmap_rdy = 1'b0;
      @(negedge clk);
      total++;
      if ({ofmap_vld, ofmap_last, busy, done, overflow} !== 5'b0 || ofmap !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL rmd_abort: got flags %b data %h want %b %h", {ofmap_vld, ofmap_last, busy, done, overflow}, ofmap, 5'b0, 16'h0000);
      end
      rst = 1'b0;
      exp_q.delete();
      for (int p = 0; p < P; p++)
         for (int c = 0; c < W; c++)
            for (int x = 0; x < X; x++)
               stim[p][c][x] = D'($urandom_range(0, 4095)) - 16'sd2048;
      start_tile();
      run_accum(1, -1);
      drain_collect(100, 300);
      total++;
      if (obs_q.size() !== exp_q.size() || timed_out !== 0) begin
         bad++;
         $display("[TB] FAIL rmd_count: got %0d want %0d (timeout %0d)", obs_q.size(), exp_q.size(), timed_out);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL rmd_elem[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
      total++;
      if ({done, ofmap_vld, busy} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL rmd_done: got %b want %b", {done, ofmap_vld, busy}, 3'b100);
      end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_staggered();
      test_saturation();
      test_backpressure();
      test_errors();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
